tdm_demux4: RTL and testbench

//  4-channel time-division demultiplexer. It is the receive-end counterpart of the 4:1 mux path.
//  A serial beat stream carries slots 0..3, with in_frame marking slot 0.
//  The block routes each beat to channel register out0..out3 and pulses out_valid per complete frame.
//  It tracks frame alignment with a HUNT/LOCKED state machine and flags sync errors.

---
 rtl/tdm_demux4.sv | 150 +++++++++++++++
 tb/tb_tdm_demux4.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// 4-channel TDM receive demultiplexer with HUNT/LOCKED frame alignment.
// Define TDM_LATCH_EN to commit out0..out3 together on frame completion.
module tdm_demux4 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_frame,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic         out_valid,
  output logic         sync_err,
  output logic         locked
);

  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [W-1:0]        out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic                out_valid_q, out_valid_d;
  logic                sync_err_q, sync_err_d;
  logic                cap;
  logic [SLOT_W-1:0]   cap_slot;
`ifdef TDM_LATCH_EN
  logic [W-1:0]        sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      slot_q      <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
`ifdef TDM_LATCH_EN
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out3_q      <= out3_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
`ifdef TDM_LATCH_EN
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
`endif
    end
  end

  // Alignment tracking and slot routing
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out3_d      = out3_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    cap         = 1'b0;
    cap_slot    = '0;
`ifdef TDM_LATCH_EN
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
`endif

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (in_frame) begin
            cap     = 1'b1;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if ((slot_q == SLOT_W'(0)) && !in_frame) begin
            sync_err_d = 1'b1;
            state_d    = ST_HUNT;
            slot_d     = '0;
          end else if (in_frame) begin
            // Early frame marker restarts the frame at slot 0
            cap        = 1'b1;
            sync_err_d = (slot_q != SLOT_W'(0));
          end else begin
            cap      = 1'b1;
            cap_slot = slot_q;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (cap) begin
      slot_d = cap_slot + SLOT_W'(1);
      case (cap_slot)
`ifdef TDM_LATCH_EN
        2'd0: sh0_d = in_data;
        2'd1: sh1_d = in_data;
        2'd2: sh2_d = in_data;
        default: begin
          out0_d      = sh0_q;
          out1_d      = sh1_q;
          out2_d      = sh2_q;
          out3_d      = in_data;
          out_valid_d = 1'b1;
        end
`else
        2'd0: out0_d = in_data;
        2'd1: out1_d = in_data;
        2'd2: out2_d = in_data;
        default: begin
          out3_d      = in_data;
          out_valid_d = 1'b1;
        end
`endif
      endcase
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4; expected values hand-computed for both
// direct and latched (TDM_LATCH_EN) builds.
module tb_tdm_demux4;

  localparam int unsigned W = 1;
`ifdef TDM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_frame;
  logic [W-1:0] in_data;
  logic [W-1:0] out0, out1, out2, out3;
  logic         out_valid;
  logic         sync_err;
  logic         locked;

  int checks = 0;
  int errors = 0;
  int pulses;

  tdm_demux4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_frame  (in_frame),
    .in_data   (in_data),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .sync_err  (sync_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the edge
  task automatic step(input logic v, input logic f, input logic d);
    in_valid = v;
    in_frame = f;
    in_data  = W'(d);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return 8'({out0, out1, out2, out3});
  endfunction

  function automatic logic [7:0] sel(input logic [7:0] direct, input logic [7:0] latched);
    return LATCH ? latched : direct;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_frame = 1'b0; in_data = '0;

    // 1 reset with active inputs
    step(1, 1, 1);
    step(1, 1, 1);
    check("rst_outs", outs(), 8'b0000);
    check("rst_ovalid", 8'(out_valid), 8'd0);
    check("rst_serr", 8'(sync_err), 8'd0);
    check("rst_locked", 8'(locked), 8'd0);
    rst_n = 1'b1;

    // 2 nominal frame 1,0,1,1
    step(1, 1, 1);
    check("nom_b1_locked", 8'(locked), 8'd1);
    check("nom_b1_outs", outs(), sel(8'b1000, 8'b0000));
    step(1, 0, 0);
    check("nom_b2_outs", outs(), sel(8'b1000, 8'b0000));
    step(1, 0, 1);
    check("nom_b3_outs", outs(), sel(8'b1010, 8'b0000));
    check("nom_b3_ovalid", 8'(out_valid), 8'd0);
    step(1, 0, 1);
    check("nom_b4_outs", outs(), 8'b1011);
    check("nom_b4_ovalid", 8'(out_valid), 8'd1);
    check("nom_b4_serr", 8'(sync_err), 8'd0);
    step(0, 0, 0);
    check("nom_idle_ovalid", 8'(out_valid), 8'd0);
    check("nom_idle_outs", outs(), 8'b1011);

    // 3 gapped beats, same frame
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, (i == 0), (i != 1));
      if (out_valid) pulses++;
      for (int g = 0; g < 3; g++) begin
        step(0, 1, 0);
        check("gap_ovalid", 8'(out_valid), 8'd0);
        check("gap_outs", outs(), 8'b1011);
      end
    end
    check("gap_pulses", 8'(pulses), 8'd1);
    check("gap_locked", 8'(locked), 8'd1);

    // 4 early frame on slot 2
    step(1, 1, 0);
    check("early_b1_outs", outs(), sel(8'b0011, 8'b1011));
    step(1, 0, 1);
    check("early_b2_outs", outs(), sel(8'b0111, 8'b1011));
    step(1, 1, 0);
    check("early_serr", 8'(sync_err), 8'd1);
    check("early_locked", 8'(locked), 8'd1);
    check("early_ovalid", 8'(out_valid), 8'd0);
    check("early_outs", outs(), sel(8'b0111, 8'b1011));
    step(1, 0, 1);
    check("early_serr_drop", 8'(sync_err), 8'd0);
    step(1, 0, 0);
    check("early_s2_outs", outs(), sel(8'b0101, 8'b1011));
    check("early_s2_ovalid", 8'(out_valid), 8'd0);
    step(1, 0, 0);
    check("early_done_ovalid", 8'(out_valid), 8'd1);
    check("early_done_outs", outs(), 8'b0100);

    // 5 missing frame marker
    step(1, 0, 1);
    check("miss_serr", 8'(sync_err), 8'd1);
    check("miss_locked", 8'(locked), 8'd0);
    check("miss_ovalid", 8'(out_valid), 8'd0);
    check("miss_outs", outs(), 8'b0100);
    step(1, 0, 1);
    step(1, 0, 0);
    check("hunt_serr", 8'(sync_err), 8'd0);
    check("hunt_locked", 8'(locked), 8'd0);
    check("hunt_outs", outs(), 8'b0100);
    step(1, 1, 1);
    check("relock_locked", 8'(locked), 8'd1);
    check("relock_outs", outs(), sel(8'b1100, 8'b0100));
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    check("relock_ovalid", 8'(out_valid), 8'd1);
    check("relock_outs_done", outs(), 8'b1011);

    // 6 reset mid-frame then frame 0,1,1,0
    step(1, 1, 0);
    step(1, 0, 0);
    rst_n = 1'b0;
    step(1, 1, 1);
    check("mrst_outs", outs(), 8'b0000);
    check("mrst_locked", 8'(locked), 8'd0);
    check("mrst_ovalid", 8'(out_valid), 8'd0);
    check("mrst_serr", 8'(sync_err), 8'd0);
    rst_n = 1'b1;
    step(1, 0, 1);
    check("mrst_drop_outs", outs(), 8'b0000);
    check("mrst_drop_locked", 8'(locked), 8'd0);
    pulses = 0;
    step(1, 1, 0); if (out_valid) pulses++;
    step(1, 0, 1); if (out_valid) pulses++;
    step(1, 0, 1); if (out_valid) pulses++;
    step(1, 0, 0); if (out_valid) pulses++;
    check("mrst_outs_done", outs(), 8'b0110);
    check("mrst_ovalid", 8'(out_valid), 8'd1);
    step(0, 0, 0);
    if (out_valid) pulses++;
    check("mrst_pulses", 8'(pulses), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
